module_ctrl_registro: RTL and testbench
=======================================

Name: module_ctrl_registro

Overview:
Round-robin write controller that shares the 4-bit clock-enabled register bank (one flip-flop per bit, common CE) among N_REQ requesters.
- Each requester presents a data nibble and a four-phase req/ack handshake.
- The controller picks one requester, drives that requester's nibble onto the register's data inputs, and pulses the register's CE for exactly one cycle.
- It then acknowledges the requester and waits for it to release req.
- It runs in the same clock domain as the register, i.e. the wizard-generated 10 MHz clock.

Parameters:
N_REQ, 3, number of requesters (2..8).
WIDTH, 4, data width; matches the register's bit count.
CNT_W, 8, width of the completed-write counter.

Ports:
clk  in  1  clock; the same clock as the controlled register.
rst  in  1  synchronous, active-high reset.
req_i  in  N_REQ  per-requester write request, level; bit k belongs to requester k.
data_i  in  N_REQ*WIDTH  requester k's nibble is at data_i[k*WIDTH +: WIDTH].
ack_o  out  N_REQ  one-cycle acknowledge to the granted requester.
grant_o  out  N_REQ  one-hot owner of the register; all zero when idle.
dp_d_o  out  WIDTH  data to the register's D inputs (dp_o[3] is the MSB).
dp_ce_o  out  1  clock enable to the register.
busy_o  out  1  high when the state is not IDLE.
wr_count_o  out  CNT_W  number of completed writes; wraps around.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high, and has priority over all other logic.
- Reset values: state=IDLE, grant_o=0, ack_o=0, dp_ce_o=0, busy_o=0, dp_d_o=0, wr_count_o=0, rr_ptr=N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, LOAD, ACK, RELEASE. All outputs are registered or Moore-decoded from state; none is combinational from inputs.
- IDLE:
  - If any req_i bit is set at the edge, grant the first requesting index searching rr_ptr+1, rr_ptr+2, … modulo N_REQ.
  - On that edge: grant_o becomes one-hot, dp_d_o captures that requester's data_i slice, rr_ptr takes the granted index, and the state moves to LOAD.
  - With no requests, stay in IDLE and leave all outputs unchanged.
- LOAD: dp_ce_o=1 for this single cycle, so the register loads dp_d_o at the next edge. Next state is ACK.
- ACK: ack_o[g]=1 for this single cycle, and wr_count_o increments at the exiting edge (2^CNT_W-1 wraps to 0). Next state is RELEASE.
- RELEASE:
  - Stay until req_i[g]=0 is sampled; then clear grant_o and go to IDLE.
  - Other requests stay pending; none is dropped.
- Latency: req sampled at edge E0 → dp_ce_o high in cycle E0..E1 → ack_o high in cycle E1..E2. The earliest next grant is at E4, so throughput is at most one write per 4 cycles.
- dp_d_o is frozen from grant until the next grant. Changes on data_i after grant are ignored. dp_d_o is not cleared on return to IDLE.
- If the granted requester drops req during LOAD or ACK, the transfer still completes with CE and ack, then leaves RELEASE on the next edge.
- A non-granted requester that asserts or drops req mid-transfer has no effect until IDLE.
- Simultaneous requests are resolved by round-robin only. With all requesters held active, grants cycle 0,1,2,0,… (for N_REQ=3).
- Reset mid-operation:
  - Reset in LOAD: the CE pulse still occurs during that cycle, but no ack follows and wr_count_o is not incremented.
  - Reset in ACK: the ack for the current cycle is issued, but wr_count_o is not incremented.
  - The requester must treat the missing ack as an abort.
- ack_o and dp_ce_o are never high in the same cycle. At most one ack_o bit is high at any time.
- busy_o = (state != IDLE).

Test Plan:
1. Reset: assert rst 2 cycles with req_i=3'b111 → all outputs 0, no grant until the cycle after rst falls; then grant_o=3'b001.
2. Single write: req_i[1]=1, data_i[7:4]=4'hA → next edge grant_o=3'b010 and dp_d_o=4'hA; dp_ce_o high exactly 1 cycle; ack_o=3'b010 the following cycle; wr_count_o=1; the register reads 4'hA after the CE edge.
3. Round robin: all three req held, each dropping req for one cycle after its ack → grant order 0,1,2,0,1,2; data 4'h1/4'h2/4'h3 land in that order.
4. Sticky request: req0 held high after ack while req2 is pending → remain in RELEASE with busy_o=1 and no further CE; drop req0 → req2 granted 2 edges later.
5. Data change after grant: data_i slice changes from 4'h5 to 4'hC during LOAD → dp_d_o and the register hold 4'h5.
6. Reset mid-transfer and wrap:
   - Pulse rst in LOAD → CE still seen that cycle, no ack, wr_count_o stays 0.
   - Separately, 256 back-to-back writes → wr_count_o returns to 0.

Source files
------------

// File: rtl/module_ctrl_registro.sv
`default_nettype none
// ============================================================================
// module_ctrl_registro : round-robin req/ack write controller for a CE register
// Revision: 1.0
// ============================================================================
module module_ctrl_registro #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] data_i,
    output logic [N_REQ-1:0]       ack_o,
    output logic [N_REQ-1:0]       grant_o,
    output logic [WIDTH-1:0]       dp_d_o,
    output logic                   dp_ce_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       wr_count_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   ack_q;
    logic               ce_q;
    logic               busy_q;
    logic [WIDTH-1:0]   dp_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PTR_W-1:0]   rr_ptr_q;

    logic               found_d;
    logic [PTR_W-1:0]   gidx_d;
    logic [WIDTH-1:0]   data_d;

    // Search starts just past the last granted index so every requester gets a turn.
    always_comb begin
        found_d = 1'b0;
        gidx_d  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found_d && req_i[(int'(rr_ptr_q) + i) % N_REQ]) begin
                found_d = 1'b1;
                gidx_d  = PTR_W'((int'(rr_ptr_q) + i) % N_REQ);
            end
        end
        data_d = data_i[int'(gidx_d)*WIDTH +: WIDTH];
    end

    // rr_ptr_q doubles as the index of the current owner while a transfer runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ack_q    <= '0;
            ce_q     <= 1'b0;
            busy_q   <= 1'b0;
            dp_q     <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= PTR_W'(N_REQ - 1);
        end else begin
            ce_q  <= 1'b0;
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        grant_q  <= {{(N_REQ-1){1'b0}}, 1'b1} << gidx_d;
                        dp_q     <= data_d;
                        rr_ptr_q <= gidx_d;
                        ce_q     <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    ack_q   <= grant_q;
                    state_q <= ACK;
                end
                ACK: begin
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    if (!req_i[rr_ptr_q]) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o      = ack_q;
    assign grant_o    = grant_q;
    assign dp_d_o     = dp_q;
    assign dp_ce_o    = ce_q;
    assign busy_o     = busy_q;
    assign wr_count_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_module_ctrl_registro.sv
`default_nettype none
`timescale 1ns/1ps
// Directed-vector bench for module_ctrl_registro with a behavioural CE register on dp_d_o.
module tb_module_ctrl_registro;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_i;
    logic [11:0] data_i;
    logic [2:0]  ack_o;
    logic [2:0]  grant_o;
    logic [3:0]  dp_d_o;
    logic        dp_ce_o;
    logic        busy_o;
    logic [7:0]  wr_count_o;

    logic [3:0]  reg_q = 4'h0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [11:0] data;
        logic [2:0]  grant;
        logic [2:0]  ack;
        logic        ce;
        logic        busy;
        logic [3:0]  dp;
        logic [7:0]  cnt;
        logic [3:0]  rg;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    module_ctrl_registro #(.N_REQ(3), .WIDTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .data_i     (data_i),
        .ack_o      (ack_o),
        .grant_o    (grant_o),
        .dp_d_o     (dp_d_o),
        .dp_ce_o    (dp_ce_o),
        .busy_o     (busy_o),
        .wr_count_o (wr_count_o)
    );

    always #50 clk = ~clk;

    // The controlled 4-bit register: plain flops with a common clock enable.
    always @(posedge clk) if (dp_ce_o) reg_q <= dp_d_o;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (dp_ce_o && (|ack_o)) begin
                n_err++;
                $display("FAIL ce_ack_overlap: ce=%b ack=%b, required not both", dp_ce_o, ack_o);
            end
            if (!$onehot0(ack_o)) begin
                n_err++;
                $display("FAIL ack_onehot: ack=%b, required at most one bit", ack_o);
            end
        end
    end

    task automatic add(input logic r, input logic [2:0] rq, input logic [11:0] dt,
                       input logic [2:0] gr, input logic [2:0] ak, input logic ce,
                       input logic bs, input logic [3:0] dp, input logic [7:0] cn,
                       input logic [3:0] rg);
        vecs[nv].rst   = r;
        vecs[nv].req   = rq;
        vecs[nv].data  = dt;
        vecs[nv].grant = gr;
        vecs[nv].ack   = ak;
        vecs[nv].ce    = ce;
        vecs[nv].busy  = bs;
        vecs[nv].dp    = dp;
        vecs[nv].cnt   = cn;
        vecs[nv].rg    = rg;
        nv++;
    endtask

    task automatic step(input logic r, input logic [2:0] rq, input logic [11:0] dt);
        rst    = r;
        req_i  = rq;
        data_i = dt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         c;
        logic [3:0] prev;
        logic [2:0] gr;
        logic [3:0] d;
        logic [27:0] got, exp;
        logic [7:0] exp_cnt;

        rst = 1'b1; req_i = 3'b111; data_i = 12'h321;

        // Reset held with all requests active, then round robin 0,1,2,0,1,2.
        add(1, 3'b111, 12'h321, 3'b000, 3'b000, 0, 0, 4'h0, 8'd0, 4'h0);
        add(1, 3'b111, 12'h321, 3'b000, 3'b000, 0, 0, 4'h0, 8'd0, 4'h0);
        c = 0; prev = 4'h0;
        for (int k = 0; k < 6; k++) begin
            gr = 3'(1 << (k % 3));
            d  = 4'((k % 3) + 1);
            add(0, 3'b111,       12'h321, gr,     3'b000, 1, 1, d, 8'(c),   prev);
            add(0, 3'b111,       12'h321, gr,     gr,     0, 1, d, 8'(c),   d);
            add(0, 3'b111,       12'h321, gr,     3'b000, 0, 1, d, 8'(c+1), d);
            add(0, 3'b111 & ~gr, 12'h321, 3'b000, 3'b000, 0, 0, d, 8'(c+1), d);
            c++; prev = d;
        end
        // Single write from requester 1.
        add(0, 3'b010, 12'h0A0, 3'b010, 3'b000, 1, 1, 4'hA, 8'd6, 4'h3);
        add(0, 3'b010, 12'h0A0, 3'b010, 3'b010, 0, 1, 4'hA, 8'd6, 4'hA);
        add(0, 3'b010, 12'h0A0, 3'b010, 3'b000, 0, 1, 4'hA, 8'd7, 4'hA);
        add(0, 3'b000, 12'h0A0, 3'b000, 3'b000, 0, 0, 4'hA, 8'd7, 4'hA);
        // Data changes after grant are ignored.
        add(0, 3'b001, 12'h005, 3'b001, 3'b000, 1, 1, 4'h5, 8'd7, 4'hA);
        add(0, 3'b001, 12'h00C, 3'b001, 3'b001, 0, 1, 4'h5, 8'd7, 4'h5);
        add(0, 3'b001, 12'h00C, 3'b001, 3'b000, 0, 1, 4'h5, 8'd8, 4'h5);
        add(0, 3'b000, 12'h00C, 3'b000, 3'b000, 0, 0, 4'h5, 8'd8, 4'h5);
        // Sticky req0 holds RELEASE while req2 waits.
        add(0, 3'b001, 12'h709, 3'b001, 3'b000, 1, 1, 4'h9, 8'd8, 4'h5);
        add(0, 3'b101, 12'h709, 3'b001, 3'b001, 0, 1, 4'h9, 8'd8, 4'h9);
        add(0, 3'b101, 12'h709, 3'b001, 3'b000, 0, 1, 4'h9, 8'd9, 4'h9);
        add(0, 3'b101, 12'h709, 3'b001, 3'b000, 0, 1, 4'h9, 8'd9, 4'h9);
        add(0, 3'b101, 12'h709, 3'b001, 3'b000, 0, 1, 4'h9, 8'd9, 4'h9);
        add(0, 3'b100, 12'h709, 3'b000, 3'b000, 0, 0, 4'h9, 8'd9, 4'h9);
        add(0, 3'b100, 12'h709, 3'b100, 3'b000, 1, 1, 4'h7, 8'd9, 4'h9);
        add(0, 3'b100, 12'h709, 3'b100, 3'b100, 0, 1, 4'h7, 8'd9, 4'h7);
        add(0, 3'b100, 12'h709, 3'b100, 3'b000, 0, 1, 4'h7, 8'd10, 4'h7);
        add(0, 3'b000, 12'h709, 3'b000, 3'b000, 0, 0, 4'h7, 8'd10, 4'h7);
        // Granted requester drops req during LOAD: transfer still completes.
        add(0, 3'b010, 12'h0B0, 3'b010, 3'b000, 1, 1, 4'hB, 8'd10, 4'h7);
        add(0, 3'b000, 12'h0B0, 3'b010, 3'b010, 0, 1, 4'hB, 8'd10, 4'hB);
        add(0, 3'b000, 12'h0B0, 3'b010, 3'b000, 0, 1, 4'hB, 8'd11, 4'hB);
        add(0, 3'b000, 12'h0B0, 3'b000, 3'b000, 0, 0, 4'hB, 8'd11, 4'hB);
        // Reset in LOAD: CE lands in the register, no ack, count cleared.
        add(0, 3'b100, 12'h600, 3'b100, 3'b000, 1, 1, 4'h6, 8'd11, 4'hB);
        add(1, 3'b100, 12'h600, 3'b000, 3'b000, 0, 0, 4'h0, 8'd0,  4'h6);
        add(0, 3'b000, 12'h600, 3'b000, 3'b000, 0, 0, 4'h0, 8'd0,  4'h6);
        // Reset in ACK: ack is seen, count not incremented.
        add(0, 3'b001, 12'h00D, 3'b001, 3'b000, 1, 1, 4'hD, 8'd0, 4'h6);
        add(0, 3'b001, 12'h00D, 3'b001, 3'b001, 0, 1, 4'hD, 8'd0, 4'hD);
        add(1, 3'b001, 12'h00D, 3'b000, 3'b000, 0, 0, 4'h0, 8'd0, 4'hD);
        add(0, 3'b000, 12'h00D, 3'b000, 3'b000, 0, 0, 4'h0, 8'd0, 4'hD);

        for (int i = 0; i < nv; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].data);
            got = {grant_o, ack_o, dp_ce_o, busy_o, dp_d_o, wr_count_o, reg_q};
            exp = {vecs[i].grant, vecs[i].ack, vecs[i].ce, vecs[i].busy,
                   vecs[i].dp, vecs[i].cnt, vecs[i].rg};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL vec%0d: got grant=%b ack=%b ce=%b busy=%b dp=%h cnt=%0d reg=%h, required grant=%b ack=%b ce=%b busy=%b dp=%h cnt=%0d reg=%h",
                         i, grant_o, ack_o, dp_ce_o, busy_o, dp_d_o, wr_count_o, reg_q,
                         vecs[i].grant, vecs[i].ack, vecs[i].ce, vecs[i].busy,
                         vecs[i].dp, vecs[i].cnt, vecs[i].rg);
            end
        end

        // 256 back-to-back writes: counter wraps to 0.
        exp_cnt = 8'd0;
        for (int w = 0; w < 256; w++) begin
            step(0, 3'b111, 12'h321);
            step(0, 3'b111, 12'h321);
            n_vec++;
            if (ack_o == 3'b000) begin
                n_err++;
                $display("FAIL wrap_ack%0d: ack=%b, required nonzero", w, ack_o);
            end
            step(0, 3'b111, 12'h321);
            step(0, 3'b000, 12'h321);
            exp_cnt = exp_cnt + 8'd1;
            n_vec++;
            if (wr_count_o !== exp_cnt || busy_o !== 1'b0) begin
                n_err++;
                $display("FAIL wrap_cnt%0d: cnt=%0d busy=%b, required cnt=%0d busy=0",
                         w, wr_count_o, busy_o, exp_cnt);
            end
        end
        n_vec++;
        if (wr_count_o !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_zero: cnt=%0d, required 0", wr_count_o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
